// File: rtl/fpdiv16_iter.sv
// Iterative binary16 divider (Quotient = A / B): radix-2 restoring divide, one quotient bit per cycle.
// Latency 14 cycles from the start-capture edge (2 for special operands); one operation in flight.
// Build option FPDIV_RNE_EN: defined -> round to nearest even, undefined -> truncate toward zero.
module fpdiv16_iter #(
  parameter int WIDTH = 16,
  parameter int QBITS = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] Quotient,
  output logic             overflow,
  output logic             underflow,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_ROUND} state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        a_q, b_q;
  logic                    sign_q;
  logic signed [6:0]       exp_q;
  logic [11:0]             rem_q;
  logic [10:0]             mb_q;
  logic [QBITS-1:0]        quo_q;
  logic [3:0]              cnt_q;
  logic                    special_q, spec_dz_q;
  logic [WIDTH-1:0]        spec_res_q;
  logic                    busy_q, valid_q, ovf_q, unf_q, dz_q;
  logic [WIDTH-1:0]        quot_q;

  // Operand decode, biased exponent difference and special-case selection for PREP
  logic              sign_d, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_lt_b;
  logic [10:0]       ma, mb;
  logic signed [6:0] exp_raw;
  logic              special_d, spec_dz_d;
  logic [WIDTH-1:0]  spec_res_d;
  always_comb begin
    sign_d     = a_q[15] ^ b_q[15];
    a_zero     = (a_q[14:10] == 5'd0);
    b_zero     = (b_q[14:10] == 5'd0);
    a_inf      = (a_q[14:10] == 5'd31) && (a_q[9:0] == 10'd0);
    b_inf      = (b_q[14:10] == 5'd31) && (b_q[9:0] == 10'd0);
    a_nan      = (a_q[14:10] == 5'd31) && (a_q[9:0] != 10'd0);
    b_nan      = (b_q[14:10] == 5'd31) && (b_q[9:0] != 10'd0);
    ma         = {1'b1, a_q[9:0]};
    mb         = {1'b1, b_q[9:0]};
    a_lt_b     = (ma < mb);
    exp_raw    = $signed({2'b00, a_q[14:10]}) - $signed({2'b00, b_q[14:10]}) + 7'sd15;
    special_d  = 1'b1;
    spec_dz_d  = 1'b0;
    spec_res_d = 16'h7E00;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res_d = 16'h7E00;
    end else if (a_inf) begin
      spec_res_d = {sign_d, 15'h7C00};
    end else if (b_inf || a_zero) begin
      spec_res_d = {sign_d, 15'h0000};
    end else if (b_zero) begin
      spec_res_d = {sign_d, 15'h7C00};
      spec_dz_d  = 1'b1;
    end else begin
      special_d  = 1'b0;
    end
  end

  // One restoring-division step: subtract divisor when it fits, then shift remainder
  logic        q_bit;
  logic [11:0] rem_sub, rem_d;
  always_comb begin
    q_bit   = (rem_q >= {1'b0, mb_q});
    rem_sub = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_d   = rem_sub << 1;
  end

  // Rounding of the 11-bit significand, carry renormalisation and range classification
  logic              rnd_up;
  logic [11:0]       sig_r;
  logic [9:0]        frac_r;
  logic signed [6:0] exp_r;
  always_comb begin
`ifdef FPDIV_RNE_EN
    rnd_up = quo_q[0] & ((|rem_q) | quo_q[1]);
`else
    rnd_up = 1'b0;
`endif
    sig_r  = {1'b0, quo_q[QBITS-1:1]} + {11'd0, rnd_up};
    frac_r = sig_r[11] ? sig_r[10:1] : sig_r[9:0];
    exp_r  = exp_q + (sig_r[11] ? 7'sd1 : 7'sd0);
  end

  // Control FSM with datapath state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rem_q      <= '0;
      mb_q       <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      special_q  <= 1'b0;
      spec_dz_q  <= 1'b0;
      spec_res_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      quot_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          sign_q     <= sign_d;
          special_q  <= special_d;
          spec_res_q <= spec_res_d;
          spec_dz_q  <= spec_dz_d;
          mb_q       <= mb;
          // Pre-scale the dividend so the quotient lands in [1,2)
          rem_q      <= a_lt_b ? {ma, 1'b0} : {1'b0, ma};
          exp_q      <= a_lt_b ? (exp_raw - 7'sd1) : exp_raw;
          quo_q      <= '0;
          cnt_q      <= '0;
          state_q    <= special_d ? S_ROUND : S_DIV;
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[QBITS-2:0], q_bit};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(QBITS - 1)) state_q <= S_ROUND;
        end
        S_ROUND: begin
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          ovf_q   <= 1'b0;
          unf_q   <= 1'b0;
          dz_q    <= 1'b0;
          if (special_q) begin
            quot_q <= spec_res_q;
            dz_q   <= spec_dz_q;
          end else if (exp_r >= 7'sd31) begin
            quot_q <= {sign_q, 15'h7C00};
            ovf_q  <= 1'b1;
          end else if (exp_r <= 7'sd0) begin
            quot_q <= {sign_q, 15'h0000};
            unf_q  <= 1'b1;
          end else begin
            quot_q <= {sign_q, exp_r[4:0], frac_r};
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign valid_out   = valid_q;
  assign Quotient    = quot_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_fpdiv16_iter.sv
// Directed bench for fpdiv16_iter: hand-computed quotients, flags, latency and control behaviour.
module tb_fpdiv16_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, valid_out, overflow, underflow, div_by_zero;
  logic [15:0] Quotient;

  int checks = 0;
  int failures = 0;

`ifdef FPDIV_RNE_EN
  localparam logic [15:0] Q_5_3 = 16'h3EAB;
`else
  localparam logic [15:0] Q_5_3 = 16'h3EAA;
`endif

  fpdiv16_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .valid_out(valid_out), .Quotient(Quotient),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".valid"}, valid_out, 0);
    chk({tag, ".q"}, Quotient, 0);
    chk({tag, ".flags"}, {overflow, underflow, div_by_zero}, 0);
  endtask

  // Issue one operation and check latency, result, flags and the single-cycle valid pulse
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic ov, input logic un,
                        input logic dz, input int lat);
    int  n;
    bit  seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_after_start"}, busy, 1);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (valid_out) seen = 1'b1;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".q"}, Quotient, q);
    chk({tag, ".flags"}, {overflow, underflow, div_by_zero}, {ov, un, dz});
    chk({tag, ".busy_at_valid"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, ".valid_pulse"}, valid_out, 0);
    chk({tag, ".q_held"}, Quotient, q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    int first_v;

    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //      tag          A        B        Quotient ov    un    dz    lat
    run_op("8div2",     16'h4800, 16'h4000, 16'h4400, 1'b0, 1'b0, 1'b0, 14);
    run_op("m2div2",    16'hC000, 16'h4000, 16'hBC00, 1'b0, 1'b0, 1'b0, 14);
    run_op("5div3",     16'h4500, 16'h4200, Q_5_3,    1'b0, 1'b0, 1'b0, 14);
    run_op("1divm2",    16'h3C00, 16'hC000, 16'hB800, 1'b0, 1'b0, 1'b0, 14);
    run_op("divzero",   16'h3C00, 16'h0000, 16'h7C00, 1'b0, 1'b0, 1'b1, 2);
    run_op("ovf",       16'h7800, 16'h1400, 16'h7C00, 1'b1, 1'b0, 1'b0, 14);
    run_op("ovf_e31",   16'h7800, 16'h3800, 16'h7C00, 1'b1, 1'b0, 1'b0, 14);
    run_op("unf",       16'h0400, 16'h4800, 16'h0000, 1'b0, 1'b1, 1'b0, 14);
    run_op("unf_e0",    16'h0400, 16'h4000, 16'h0000, 1'b0, 1'b1, 1'b0, 14);
    run_op("unf_shift", 16'h0400, 16'h3E00, 16'h0000, 1'b0, 1'b1, 1'b0, 14);
    run_op("min_norm",  16'h0400, 16'h3C00, 16'h0400, 1'b0, 1'b0, 1'b0, 14);
    run_op("max_norm",  16'h7BFF, 16'h3C00, 16'h7BFF, 1'b0, 1'b0, 1'b0, 14);
    run_op("nan_in",    16'h7E00, 16'h3C00, 16'h7E00, 1'b0, 1'b0, 1'b0, 2);
    run_op("zero_zero", 16'h0000, 16'h0000, 16'h7E00, 1'b0, 1'b0, 1'b0, 2);
    run_op("inf_inf",   16'h7C00, 16'h7C00, 16'h7E00, 1'b0, 1'b0, 1'b0, 2);
    run_op("minf_2",    16'hFC00, 16'h4000, 16'hFC00, 1'b0, 1'b0, 1'b0, 2);
    run_op("one_inf",   16'h3C00, 16'h7C00, 16'h0000, 1'b0, 1'b0, 1'b0, 2);
    run_op("mzero_2",   16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b0, 1'b0, 2);
    run_op("subn_a",    16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0, 1'b0, 2);
    run_op("subn_b",    16'hBC00, 16'h0200, 16'hFC00, 1'b0, 1'b0, 1'b1, 2);

    // start held high: ignored while busy, re-accepted on the first idle edge
    @(negedge clk);
    A = 16'h4800; B = 16'h4000; start = 1'b1;
    @(posedge clk); #1;
    vcnt = 0; first_v = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (valid_out) begin
        vcnt++;
        if (first_v == 0) first_v = i;
      end
    end
    chk("hold_start.valid_count", vcnt, 1);
    chk("hold_start.valid_cycle", first_v, 14);
    chk("hold_start.q", Quotient, 16'h4400);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_start.reaccept_busy", busy, 1);
    vcnt = 0; first_v = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid_out) begin
        vcnt++;
        if (first_v == 0) first_v = i;
      end
    end
    chk("hold_start.second_count", vcnt, 1);
    chk("hold_start.second_cycle", first_v, 14);

    // reset during the divide iterations aborts the operation
    @(negedge clk);
    A = 16'h4500; B = 16'h4200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (valid_out) vcnt++;
    end
    chk("midreset.no_valid", vcnt, 0);
    chk("midreset.idle_busy", busy, 0);
    run_op("post_reset", 16'h4800, 16'h4000, 16'h4400, 1'b0, 1'b0, 1'b0, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
